// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and constants for the memory port arbiter
package mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   localparam logic SEL_I = 1'b0;
   localparam logic SEL_D = 1'b1;
   localparam int ABORT_DATA = 0;
endpackage

// File: rtl/mem_timeout_counter.sv
// mem_timeout_counter: saturating watchdog that flags an access the memory never answers
module mem_timeout_counter #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   logic [CNT_W-1:0] cnt;
   assign expired = cnt == CNT_W'(TIMEOUT - 1);
   // count waiting cycles, holding at the abort point so it never wraps
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= '0;
      else if (clear) cnt <= '0;
      else if (enable && !expired) cnt <= cnt + CNT_W'(1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between fetch and load/store
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_hold,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_stall,
   output logic              bus_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);
   state_t            state;
   logic              sel_q, i_done_q, d_done_q;
   logic [DATA_W-1:0] i_rdata_q, d_rdata_q, rsp_data;
   logic              i_pend, d_pend, resp, i_resp, d_resp, expired, advance;

   assign i_pend    = i_req & ~i_done_q;
   assign d_pend    = d_req & ~d_done_q;
   assign resp      = (state == WAIT) & (mem_rvalid | expired);
   assign i_resp    = resp & (sel_q == SEL_I);
   assign d_resp    = resp & (sel_q == SEL_D);
   assign bus_err   = (state == WAIT) & ~mem_rvalid & expired;
   assign rsp_data  = mem_rvalid ? mem_rdata : DATA_W'(ABORT_DATA);
   assign i_rdata   = i_resp ? rsp_data : i_rdata_q;
   assign d_rdata   = d_resp ? rsp_data : d_rdata_q;
   assign mem_stall = (i_pend & ~i_resp) | (d_pend & ~d_resp);
   assign advance   = ~mem_stall;

   mem_timeout_counter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == ISSUE),
      .enable  ((state == WAIT) & ~mem_rvalid),
      .expired (expired)
   );

   // access sequencer: data wins arbitration as the older instruction
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state     <= IDLE;
         sel_q     <= SEL_I;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_req <= 1'b0;
         case (state)
            IDLE: if (d_pend | i_pend) begin
               sel_q     <= d_pend ? SEL_D : SEL_I;
               mem_we    <= d_pend & d_we;
               mem_addr  <= d_pend ? d_addr : i_addr;
               mem_wdata <= d_wdata;
               mem_req   <= 1'b1;
               state     <= ISSUE;
            end
            ISSUE: state <= WAIT;
            WAIT: if (resp) state <= IDLE;
            default: state <= IDLE;
         endcase
      end

   // hold returned words until the pipeline consumes them; clearing wins over setting
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         i_done_q  <= 1'b0;
         d_done_q  <= 1'b0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         d_done_q <= advance ? 1'b0 : (d_resp | d_done_q);
         i_done_q <= (advance & ~i_hold) ? 1'b0 : (i_resp | i_done_q);
         if (i_resp) i_rdata_q <= rsp_data;
         if (d_resp) d_rdata_q <= rsp_data;
      end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random pipeline and memory traffic checked against a transaction model
module tb_mem_port_arbiter;
   logic        clk = 1'b0, rst = 1'b0;
   logic        i_req = 1'b0, i_hold = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
   logic        mem_stall, bus_err, mem_req, mem_we;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .i_req(i_req), .i_addr(i_addr), .i_hold(i_hold), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
      .mem_stall(mem_stall), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int          total = 0, bad = 0;
   int          cyc = 0, rsp_cyc = -100, issue_cyc = 0;
   bit          busy, issue_due, advance, quiet, have_i, have_d, cur_d, cur_we;
   logic [31:0] cur_addr, cur_wdata, exp_i, exp_d;
   logic [31:0] mem [16];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic deliver(input logic [31:0] w);
      if (cur_d) begin have_d = 1; exp_d = w; end
      else begin have_i = 1; exp_i = w; end
   endtask

   task automatic new_inputs();
      d_req   = $urandom_range(0, 1);
      d_we    = $urandom_range(0, 1);
      d_addr  = $urandom & 32'hFFFF_FFFC;
      d_wdata = $urandom;
      if (!i_hold) begin
         i_req  = $urandom_range(0, 7) != 0;
         i_addr = $urandom & 32'hFFFF_FFFC;
      end
      i_hold = $urandom_range(0, 3) == 0;
   endtask

   task automatic step();
      bit need_i, need_d, berr, busy_start, was_req, stall_exp;
      int r;
      @(posedge clk); #1;
      cyc++;
      if (advance) begin
         have_d = 0;
         if (!i_hold) have_i = 0;
         if (!quiet) new_inputs();
      end
      mem_rvalid = (cyc == rsp_cyc);
      mem_rdata  = (busy && !cur_we) ? mem[cur_addr[5:2]] : $urandom;
      @(negedge clk);
      chk("mem_req", {31'd0, mem_req}, {31'd0, issue_due});
      busy_start = busy;
      was_req = issue_due;
      berr = 0;
      if (busy) begin
         if (mem_rvalid) begin
            busy = 0;
            if (cur_we) begin mem[cur_addr[5:2]] = cur_wdata; deliver(32'd0); end
            else deliver(mem[cur_addr[5:2]]);
         end else if (cyc == issue_cyc + 4) begin
            busy = 0;
            berr = 1;
            deliver(32'd0);
         end
      end
      chk("bus_err", {31'd0, bus_err}, {31'd0, berr});
      need_d = d_req && !have_d;
      need_i = i_req && !have_i;
      if (was_req) begin
         chk("issue_needed", {31'd0, need_d | need_i}, 32'd1);
         cur_d     = need_d;
         cur_addr  = need_d ? d_addr : i_addr;
         cur_we    = need_d && d_we;
         cur_wdata = d_wdata;
         chk("mem_addr", mem_addr, cur_addr);
         chk("mem_we", {31'd0, mem_we}, {31'd0, cur_we});
         if (cur_we) chk("mem_wdata", mem_wdata, cur_wdata);
         busy = 1;
         issue_cyc = cyc;
         r = $urandom_range(0, 9);
         rsp_cyc = (r == 0) ? -100 : (r == 1) ? cyc + 5 : cyc + 1 + (r % 4);
      end
      stall_exp = need_i || need_d;
      chk("mem_stall", {31'd0, mem_stall}, {31'd0, stall_exp});
      if (have_d && d_req && !d_we) chk("d_rdata", d_rdata, exp_d);
      if (have_i && i_req) chk("i_rdata", i_rdata, exp_i);
      issue_due = !busy_start && !was_req && stall_exp;
      advance = !stall_exp;
   endtask

   task automatic model_reset();
      busy = 0; issue_due = 0; have_i = 0; have_d = 0; advance = 0;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
      chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
      chk("rst_i_rdata", i_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
   endtask

   initial begin
      bit hit;
      for (int k = 0; k < 16; k++) mem[k] = $urandom;
      model_reset();
      quiet = 0;
      #3;
      chk_reset_outputs();
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1;
      advance = 1;
      repeat (3000) step();
      hit = 0;
      for (int k = 0; k < 60 && !hit; k++) begin
         step();
         hit = mem_req;
      end
      chk("reach_issue", {31'd0, hit}, 32'd1);
      #2;
      i_req = 0; d_req = 0; i_hold = 0; rst = 0;
      #1;
      chk_reset_outputs();
      model_reset();
      quiet = 1;
      repeat (2) @(negedge clk);
      rst = 1;
      repeat (8) step();
      quiet = 0;
      advance = 1;
      repeat (3000) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified instruction/data memory between the Fetch stage (instruction read) and the Memory stage (load/store) of the 5-stage RISC-V pipeline. It arbitrates the two requesters, sequences one outstanding access at a time against a variable-latency memory, and holds each returned word until the pipeline advances. Its mem_stall output is OR'd by the hazard unit into Stall_F, Stall_D and the stage-register enables. A watchdog aborts accesses the memory never answers.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, max WAIT cycles before abort
CNT_W, 8, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
i_req  in  1  fetch request; held while stalled
i_addr  in  ADDR_W  fetch address (PC_F)
i_hold  in  1  hazard-unit stall of Fetch (load-use); blocks release of the fetched word
i_rdata  out  DATA_W  fetched instruction
d_req  in  1  data request; held while stalled
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address (ALUResult_M)
d_wdata  in  DATA_W  store data (WriteData_M)
d_rdata  out  DATA_W  load data (ReadData_M)
mem_stall  out  1  pipeline must not advance
bus_err  out  1  one-cycle pulse on watchdog abort
mem_req  out  1  one-cycle access strobe
mem_we  out  1  write enable, valid with mem_req
mem_addr  out  ADDR_W  access address, held from ISSUE through WAIT
mem_wdata  out  DATA_W  write data, held from ISSUE through WAIT
mem_rvalid  in  1  completion (read data or write ack); one per mem_req
mem_rdata  in  DATA_W  read data, valid with mem_rvalid

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; sel_q=0 (fetch); i_done_q, d_done_q=0; i_rdata_q, d_rdata_q=0; watchdog=0. Outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, bus_err=0. A reset during ISSUE/WAIT drops the access. Any later mem_rvalid is ignored because the FSM is in IDLE.
- Pending: i_pend = i_req & ~i_done_q; d_pend = d_req & ~d_done_q.
- FSM:
  - IDLE: if d_pend, set sel_q=D; else if i_pend, set sel_q=I; else stay. On selection, latch addr/we/wdata into the mem_* registers and go to ISSUE. Fetch requests force mem_we=0. Data always has priority because it is the older instruction.
  - ISSUE: mem_req=1 for exactly this cycle; go to WAIT; clear the watchdog.
  - WAIT: if mem_rvalid, this is resp for sel_q; go to IDLE. Else if watchdog==TIMEOUT-1, abort: bus_err=1, treat as resp with data 0, go to IDLE. Else increment the watchdog.
- The memory must answer no earlier than the cycle after mem_req. mem_rvalid in IDLE or ISSUE is ignored.
- Response hold: x_rdata = (resp for x this cycle) ? mem_rdata (0 on abort) : x_rdata_q. x_rdata_q is captured on resp.
- mem_stall is combinational: (i_pend & ~i_resp_now) | (d_pend & ~d_resp_now).
- Done flags, evaluated at each edge:
  - advance = ~mem_stall.
  - d_done_q: if advance then 0, else if d_resp then 1.
  - i_done_q: if advance & ~i_hold then 0, else if i_resp then 1.
  - Clear has precedence, so a word consumed in its arrival cycle is not re-held.
- Minimum latency, single request: req at cycle 0 (IDLE), mem_req at cycle 1, earliest mem_rvalid at cycle 2. mem_stall is high at cycles 0–1 and low at cycle 2.
- Both requesting in IDLE: data access completes first, then IDLE, ISSUE, WAIT for fetch. mem_stall stays high until both words have arrived.
- A store completes on mem_rvalid; mem_rdata is ignored, so d_rdata = mem_rdata is don't-care for the store.
- Watchdog never exceeds TIMEOUT-1 and does not wrap.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum IDLE/ISSUE/WAIT (2 bits);
  - SEL_I=0 and SEL_D=1;
  - ABORT_DATA = 0.
- One sub-module: mem_timeout_counter. It has clear and enable inputs and an expired output, and is parameterised by TIMEOUT and CNT_W.

Test Plan:
- Load, mem latency 1: d_req=1, d_we=0, d_addr=0x40; mem_rvalid at cycle 2 with 0xDEADBEEF. Expect mem_req only at cycle 1, mem_addr=0x40, mem_stall=1 at cycles 0–1 and 0 at cycle 2, d_rdata=0xDEADBEEF at cycle 2.
- Simultaneous requests: i_req (0x100) and d_req store (0x80, 0x12345678) at cycle 0, memory latency 3. Expect first mem_req with we=1, addr=0x80, then mem_req with we=0, addr=0x100. mem_stall falls on the fetch rvalid cycle.
- Hold: fetch returns 0x00A00093 while d_req is still pending. Expect i_rdata to stay 0x00A00093 and no second fetch access until mem_stall=0.
- i_hold: fetch completes while i_hold=1 and mem_stall=0. Expect no refetch next cycle and i_rdata held. The fetch is reissued only after i_hold falls and i_req remains asserted.
- Timeout, TIMEOUT=4: mem_rvalid is never asserted. Expect bus_err for one cycle at the 4th WAIT cycle, d_rdata=0 and mem_stall=0 that cycle. A late mem_rvalid in IDLE is ignored.
- Async reset: rst=0 in WAIT. Expect immediate mem_req=0, mem_stall=0 (no requests), FSM in IDLE, and no access reissued until a new request arrives.
